campaign_ctrl: RTL and testbench
================================

# campaign_ctrl

Run controller for the FPGA verification platform. It sequences one test campaign against the AES chip: chip reset, encrypt phase, drain, chip reset, decrypt phase, drain. It drives the data generator's `work`/`enc` controls and the chip-reset request, and derives per-phase error counts from the scoreboard's running `total`/`correct` counters. A watchdog aborts the campaign if the chip stops returning results.

## Interface
Parameters:
- `BLOCKS_PER_PHASE`, default 256: results required (scoreboard `total` delta) before `work` drops in a phase.
- `RST_HOLD`, default 64: cycles `chip_rst_req` is held per reset step.
- `QUIET_CYC`, default 1024: cycles of unchanged `total` that end a drain.
- `TIMEOUT_CYC`, default 65536: cycles of unchanged `total` that trip the watchdog. `QUIET_CYC < TIMEOUT_CYC`; both fit 32 bits.

Ports:
- `clk` in 1: platform clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a campaign. Honoured only in IDLE.
- `abort` in 1: level; ends any running campaign.
- `total` in 32: scoreboard result count.
- `correct` in 32: scoreboard match count.
- `work` out 1: generator run enable.
- `enc` out 1: generator mode; 1 = encrypt.
- `chip_rst_req` out 1: request to hold the chip in reset.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a campaign ends.
- `fail_code` out 2: 00 pass, 01 mismatch, 10 timeout, 11 aborted.
- `enc_errors` out 16: encrypt-phase error count, saturating.
- `dec_errors` out 16: decrypt-phase error count, saturating.

## Operation
- States:
  - IDLE
  - RST: counts `RST_HOLD`.
  - RUN: work=1.
  - DRAIN: work=0, waits for quiet.
  - FIN
- Sequence: IDLE →(start) RST(enc=1) → RUN → DRAIN → RST(enc=0) → RUN → DRAIN → FIN → IDLE. A `phase` register (0 = enc, 1 = dec) selects the path and `enc` = ~phase.
- `enc` changes only on RST entry, while `work` = 0.
- On `start` in IDLE:
  - latch `base_t` = total and `base_c` = correct;
  - clear `enc_errors`, `dec_errors`, `fail_code`;
  - set phase = 0.
- RST: `chip_rst_req` = 1 for exactly `RST_HOLD` cycles, then RUN. Rebase `base_t`/`base_c` on RST exit.
- RUN: `work` = 1. Leave for DRAIN when (total − base_t) mod 2^32 ≥ `BLOCKS_PER_PHASE`.
- DRAIN: `work` = 0. Exit after `QUIET_CYC` consecutive cycles with `total` unchanged. On exit, compute err = ((total − base_t) − (correct − base_c)) mod 2^32, saturated to 0xFFFF, and write it to the phase's error register.
  - After phase 0: phase = 1, go to RST.
  - After phase 1: go to FIN.
- FIN: `fail_code` = 01 if either error register ≠ 0, else 00. Pulse `done` and go to IDLE.
- Watchdog: counter cleared on every `total` change and on entry to RUN/DRAIN; counts only in RUN and DRAIN. On reaching `TIMEOUT_CYC`:
  - `fail_code` = 10 and `work` = 0;
  - error registers keep their current values;
  - pulse `done`, go to IDLE.
- Abort: `abort` = 1 in any non-IDLE state:
  - next cycle IDLE, `work` = 0, `chip_rst_req` = 0, `fail_code` = 11, `done` pulse.
  - Abort has priority over timeout and over normal transitions in the same cycle.
- `start` while busy is ignored. `start` and `abort` together in IDLE: stay in IDLE, no `done`, outputs unchanged.
- All arithmetic on `total`/`correct` is 32-bit modular, so counter wrap-around is transparent.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `work`=0, `enc`=1, `chip_rst_req`=0, `busy`=0, `done`=0, `fail_code`=00, `enc_errors`=0, `dec_errors`=0.
- `start` at cycle t → `busy`=1 and `chip_rst_req`=1 at t+1.
- `chip_rst_req` high on cycles t+1 .. t+RST_HOLD; `work`=1 from t+RST_HOLD+1.
- The threshold comparison and `total` change detection use the `total` sampled the previous cycle. `work` falls the cycle after the threshold is met.
- `done` is high for exactly one cycle, coincident with the first IDLE cycle. `fail_code` and the error registers are valid from that cycle and hold until the next accepted `start`.
- `rst` mid-campaign: all outputs return to reset values immediately (asynchronous), no `done` pulse.

## Test plan
Bench parameters: BLOCKS_PER_PHASE=4, RST_HOLD=8, QUIET_CYC=16, TIMEOUT_CYC=100.

- **Clean run.** Model returns a result every 10 cycles, all correct → `chip_rst_req` high 8 cycles twice, enc 1 then 0, `done` pulse, fail_code=00, both error registers 0.
- **Mismatches.** 2 of 5 encrypt results and 1 decrypt result incorrect → enc_errors=2, dec_errors=1, fail_code=01.
- **Stalled chip.** No results after the 2nd encrypt result → `done` exactly 100 cycles after the last `total` change, fail_code=10, `work`=0.
- **Abort and start-while-busy.** Abort during decrypt RUN → `done` the next cycle, fail_code=11. A `start` pulsed while busy beforehand has no effect.
- **Wrap-around.** `total` preset to 0xFFFF_FFFE, clean run → phase completes after 4 results, enc_errors=0.
- **Reset mid-campaign.** Assert `rst` during RST → `chip_rst_req`=0 and `busy`=0 asynchronously, no `done` pulse. A following `start` runs a normal campaign.

Source files
------------

// File: rtl/campaign_ctrl.sv
// Campaign sequencer for the AES verification platform: reset, encrypt,
// drain, reset, decrypt, drain, with watchdog and abort handling.
`timescale 1ns/1ps
module campaign_ctrl #(
  parameter int BLOCKS_PER_PHASE = 256,
  parameter int RST_HOLD         = 64,
  parameter int QUIET_CYC        = 1024,
  parameter int TIMEOUT_CYC      = 65536
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] total,
  input  logic [31:0] correct,
  output logic        work,
  output logic        enc,
  output logic        chip_rst_req,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fail_code,
  output logic [15:0] enc_errors,
  output logic [15:0] dec_errors
);

  localparam logic [31:0] BPP       = 32'(BLOCKS_PER_PHASE);
  localparam logic [31:0] HOLD_LAST = 32'(RST_HOLD - 1);
  localparam logic [31:0] QUIET     = 32'(QUIET_CYC);
  localparam logic [31:0] TMO       = 32'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST,
    S_RUN,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q, phase_d;
  logic [31:0] base_t_q, base_t_d;
  logic [31:0] base_c_q, base_c_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wd_q, wd_d;
  logic [31:0] tot_q, tot_d;
  logic        work_q, work_d;
  logic        enc_q, enc_d;
  logic        crr_q, crr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  fc_q, fc_d;
  logic [15:0] ee_q, ee_d;
  logic [15:0] de_q, de_d;

  logic        chg;
  logic [31:0] wd_nx;
  logic [31:0] err;
  logic [15:0] err_sat;

  always_comb begin
    chg     = (total != tot_q);
    wd_nx   = chg ? 32'd1 : wd_q + 32'd1;
    err     = (total - base_t_q) - (correct - base_c_q);
    err_sat = (|err[31:16]) ? 16'hFFFF : err[15:0];

    state_d  = state_q;
    phase_d  = phase_q;
    base_t_d = base_t_q;
    base_c_d = base_c_q;
    cnt_d    = cnt_q;
    wd_d     = wd_q;
    tot_d    = total;
    work_d   = work_q;
    enc_d    = enc_q;
    crr_d    = crr_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    fc_d     = fc_q;
    ee_d     = ee_q;
    de_d     = de_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d  = S_RST;
          base_t_d = total;
          base_c_d = correct;
          ee_d     = '0;
          de_d     = '0;
          fc_d     = 2'b00;
          phase_d  = 1'b0;
          enc_d    = 1'b1;
          crr_d    = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      S_RST: begin
        cnt_d = cnt_q + 32'd1;
        if (cnt_q == HOLD_LAST) begin
          state_d  = S_RUN;
          crr_d    = 1'b0;
          work_d   = 1'b1;
          base_t_d = total;
          base_c_d = correct;
          wd_d     = '0;
        end
      end
      S_RUN: begin
        wd_d = wd_nx;
        if (tot_q - base_t_q >= BPP) begin
          state_d = S_DRAIN;
          work_d  = 1'b0;
          cnt_d   = '0;
          wd_d    = '0;
        end else if (wd_nx >= TMO) begin
          state_d = S_IDLE;
          work_d  = 1'b0;
          busy_d  = 1'b0;
          fc_d    = 2'b10;
          done_d  = 1'b1;
        end
      end
      S_DRAIN: begin
        wd_d  = wd_nx;
        cnt_d = chg ? 32'd0 : cnt_q + 32'd1;
        if (!chg && (cnt_q + 32'd1 == QUIET)) begin
          if (!phase_q) begin
            ee_d    = err_sat;
            phase_d = 1'b1;
            state_d = S_RST;
            enc_d   = 1'b0;
            crr_d   = 1'b1;
            cnt_d   = '0;
          end else begin
            de_d    = err_sat;
            state_d = S_FIN;
          end
        end else if (wd_nx >= TMO) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          fc_d    = 2'b10;
          done_d  = 1'b1;
        end
      end
      S_FIN: begin
        fc_d    = (ee_q != '0 || de_q != '0) ? 2'b01 : 2'b00;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over every transition, including error capture
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      phase_d = phase_q;
      work_d  = 1'b0;
      enc_d   = enc_q;
      crr_d   = 1'b0;
      busy_d  = 1'b0;
      fc_d    = 2'b11;
      done_d  = 1'b1;
      ee_d    = ee_q;
      de_d    = de_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= 1'b0;
      base_t_q <= '0;
      base_c_q <= '0;
      cnt_q    <= '0;
      wd_q     <= '0;
      tot_q    <= '0;
      work_q   <= 1'b0;
      enc_q    <= 1'b1;
      crr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fc_q     <= 2'b00;
      ee_q     <= '0;
      de_q     <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      base_t_q <= base_t_d;
      base_c_q <= base_c_d;
      cnt_q    <= cnt_d;
      wd_q     <= wd_d;
      tot_q    <= tot_d;
      work_q   <= work_d;
      enc_q    <= enc_d;
      crr_q    <= crr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fc_q     <= fc_d;
      ee_q     <= ee_d;
      de_q     <= de_d;
    end
  end

  assign work         = work_q;
  assign enc          = enc_q;
  assign chip_rst_req = crr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign fail_code    = fc_q;
  assign enc_errors   = ee_q;
  assign dec_errors   = de_q;

endmodule

// File: tb/tb_campaign_ctrl.sv
// Bench for campaign_ctrl: a timeline model predicts every output per cycle
// from phase rules; a reactive chip model supplies total/correct.
`timescale 1ns/1ps
module tb_campaign_ctrl;

  localparam int BPP = 4;
  localparam int RH  = 8;
  localparam int QC  = 16;
  localparam int TMO = 100;
  localparam int N   = 400;
  localparam int S0  = 5;

  localparam int F_WORK = 0;
  localparam int F_ENC  = 1;
  localparam int F_CRR  = 2;
  localparam int F_BUSY = 3;
  localparam int F_DONE = 4;
  localparam int F_FC   = 5;
  localparam int F_EE   = 6;
  localparam int F_DE   = 7;

  logic        clk = 0;
  logic        rst = 0;
  logic        start = 0;
  logic        abort = 0;
  logic [31:0] total = 0;
  logic [31:0] correct = 0;
  logic        work, enc, chip_rst_req, busy, done;
  logic [1:0]  fail_code;
  logic [15:0] enc_errors, dec_errors;

  campaign_ctrl #(
    .BLOCKS_PER_PHASE(BPP),
    .RST_HOLD(RH),
    .QUIET_CYC(QC),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .abort(abort),
    .total(total),
    .correct(correct),
    .work(work),
    .enc(enc),
    .chip_rst_req(chip_rst_req),
    .busy(busy),
    .done(done),
    .fail_code(fail_code),
    .enc_errors(enc_errors),
    .dec_errors(dec_errors)
  );

  always #5 clk = ~clk;

  int nerr = 0;
  int nchk = 0;

  // scenario configuration
  logic [31:0] t0, c0;
  int glo, ghi;
  int gtab[2][6];
  int bad[2];
  int cap[2];
  int ab_off, ign_start, both_cyc;

  // stimulus and expected timeline
  logic [31:0] tot[N];
  logic [31:0] cor[N];
  bit start_a[N];
  bit abort_a[N];
  int ex[8][N];
  int ab;

  // observations
  int done_cyc, done_cnt, crr_cnt, wfall;
  bit prev_work;

  string fn[8] = '{"work", "enc", "chip_rst_req", "busy",
                   "done", "fail_code", "enc_errors", "dec_errors"};

  task automatic chk(string nm, int k, int act, int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, k, act, exp);
    end
  endtask

  task automatic fill(int from, int to, int f, int v);
    for (int k = from; k <= to && k < N; k++) ex[f][k] = v;
  endtask

  task automatic idle_from(int x, int fc);
    fill(x, N - 1, F_WORK, 0);
    fill(x, N - 1, F_CRR, 0);
    fill(x, N - 1, F_BUSY, 0);
    fill(x, N - 1, F_FC, fc);
  endtask

  task automatic add_res(int a, bit ok);
    for (int k = a; k < N; k++) begin
      tot[k] = tot[k] + 32'd1;
      if (ok) cor[k] = cor[k] + 32'd1;
    end
  endtask

  function automatic int gap_of(int p, int n);
    if (n < 6 && gtab[p][n] != 0) return gtab[p][n];
    return int'($urandom_range(ghi, glo));
  endfunction

  task automatic build();
    int cur, r, rs, c, d, a, n, q, anchor, dn, rs1, fc;
    logic [31:0] bt, bc, e;
    bit tmo;
    for (int k = 0; k < N; k++) begin
      tot[k] = t0;
      cor[k] = c0;
      start_a[k] = 0;
      abort_a[k] = 0;
      for (int f = 0; f < 8; f++) ex[f][k] = 0;
      ex[F_ENC][k] = 1;
    end
    start_a[S0] = 1;
    rs1 = -1;
    ab = -1;
    tmo = 0;
    cur = S0 + 1;
    for (int p = 0; p < 2 && !tmo; p++) begin
      r = cur;
      fill(r, N - 1, F_BUSY, 1);
      fill(r, r + RH - 1, F_CRR, 1);
      fill(r, N - 1, F_ENC, (p == 0) ? 1 : 0);
      bt = tot[r + RH - 1];
      bc = cor[r + RH - 1];
      rs = r + RH;
      if (p == 1) rs1 = rs;
      a = rs;
      n = 0;
      c = -1;
      while (1) begin
        a += gap_of(p, n);
        if (cap[p] >= 0 && n >= cap[p]) break;
        if (c >= 0 && a > c + 2) break;
        add_res(a, !bad[p][n]);
        n++;
        if (n == BPP) c = a + 1;
      end
      if (c < 0) begin
        anchor = rs;
        for (int k = rs + 1; k < N; k++)
          if (tot[k] != tot[k - 1]) anchor = k;
        dn = anchor + TMO;
        fill(rs, dn - 1, F_WORK, 1);
        idle_from(dn, 2);
        ex[F_DONE][dn] = 1;
        tmo = 1;
      end else begin
        fill(rs, c, F_WORK, 1);
        q = 0;
        d = -1;
        for (int k = c + 1; k < N && d < 0; k++) begin
          if (tot[k] != tot[k - 1]) q = 0;
          else q++;
          if (q == QC) d = k;
        end
        e = (tot[d] - bt) - (cor[d] - bc);
        fill(d + 1, N - 1, (p == 0) ? F_EE : F_DE,
             (e > 32'hFFFF) ? 32'hFFFF : int'(e));
        cur = d + 1;
      end
    end
    if (!tmo) begin
      fc = (ex[F_EE][N - 1] != 0 || ex[F_DE][N - 1] != 0) ? 1 : 0;
      idle_from(cur + 1, fc);
      ex[F_DONE][cur + 1] = 1;
    end
    if (ab_off >= 0 && rs1 >= 0) begin
      ab = rs1 + ab_off;
      abort_a[ab] = 1;
      for (int k = ab + 1; k < N; k++) begin
        tot[k] = tot[ab];
        cor[k] = cor[ab];
      end
      idle_from(ab + 1, 3);
      fill(ab + 1, N - 1, F_DONE, 0);
      ex[F_DONE][ab + 1] = 1;
      fill(ab + 1, N - 1, F_EE, ex[F_EE][ab]);
      fill(ab + 1, N - 1, F_DE, ex[F_DE][ab]);
      fill(ab + 1, N - 1, F_ENC, ex[F_ENC][ab]);
    end
    if (ign_start >= 0) start_a[ign_start] = 1;
    if (both_cyc >= 0) begin
      start_a[both_cyc] = 1;
      abort_a[both_cyc] = 1;
    end
  endtask

  task automatic cmp(int k);
    int act[8];
    act[F_WORK] = int'(work);
    act[F_ENC]  = int'(enc);
    act[F_CRR]  = int'(chip_rst_req);
    act[F_BUSY] = int'(busy);
    act[F_DONE] = int'(done);
    act[F_FC]   = int'(fail_code);
    act[F_EE]   = int'(enc_errors);
    act[F_DE]   = int'(dec_errors);
    for (int f = 0; f < 8; f++) chk(fn[f], k, act[f], ex[f][k]);
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = k;
    end
    if (chip_rst_req) crr_cnt++;
    if (prev_work && !work && wfall < 0) wfall = k;
    prev_work = work;
  endtask

  task automatic cfg_default();
    t0 = 32'd100;
    c0 = 32'd100;
    glo = 10;
    ghi = 10;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 6; i++) gtab[p][i] = 0;
      bad[p] = 0;
      cap[p] = -1;
    end
    ab_off = -1;
    ign_start = -1;
    both_cyc = -1;
  endtask

  task automatic cfg_random();
    cfg_default();
    t0 = $urandom;
    c0 = $urandom;
    glo = 1;
    ghi = 12;
    bad[0] = int'($urandom_range(31, 0));
    bad[1] = int'($urandom_range(31, 0));
    if ($urandom_range(3, 0) == 0) ab_off = int'($urandom_range(4, 1));
  endtask

  task automatic run_scn(bit do_rst);
    build();
    if (do_rst) begin
      @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0;
    end
    done_cyc = -1;
    done_cnt = 0;
    crr_cnt = 0;
    wfall = -1;
    prev_work = 0;
    for (int k = 0; k < N; k++) begin
      @(posedge clk);
      #1;
      start = start_a[k];
      abort = abort_a[k];
      total = tot[k];
      correct = cor[k];
      @(negedge clk);
      cmp(k);
    end
    start = 0;
    abort = 0;
  endtask

  function automatic int last_change();
    int lc = 0;
    for (int k = 1; k < N; k++)
      if (tot[k] != tot[k - 1]) lc = k;
    return lc;
  endfunction

  initial begin
    int idx;

    // clean run
    cfg_default();
    run_scn(1);
    chk("clean_crr_cycles", -1, crr_cnt, 16);
    chk("clean_done_cnt", -1, done_cnt, 1);
    chk("clean_fc", -1, int'(fail_code), 0);
    chk("clean_ee", -1, int'(enc_errors), 0);
    chk("clean_de", -1, int'(dec_errors), 0);

    // mismatches: results 1 and 3 of encrypt, result 2 of decrypt
    cfg_default();
    gtab[0] = '{10, 10, 10, 10, 2, 0};
    bad[0] = 32'b01010;
    bad[1] = 32'b00100;
    run_scn(1);
    chk("mis_ee", -1, int'(enc_errors), 2);
    chk("mis_de", -1, int'(dec_errors), 1);
    chk("mis_fc", -1, int'(fail_code), 1);

    // stalled chip after two encrypt results
    cfg_default();
    cap[0] = 2;
    run_scn(1);
    chk("stall_done_gap", -1, done_cyc - last_change(), 100);
    chk("stall_fc", -1, int'(fail_code), 2);
    chk("stall_work", -1, int'(work), 0);

    // abort in decrypt run, start+abort in idle, start while busy
    cfg_default();
    ab_off = 3;
    both_cyc = 2;
    ign_start = S0 + 4;
    run_scn(1);
    chk("abort_done_cyc", -1, done_cyc, ab + 1);
    chk("abort_done_cnt", -1, done_cnt, 1);
    chk("abort_fc", -1, int'(fail_code), 3);

    // wrap-around of the scoreboard counters
    cfg_default();
    t0 = 32'hFFFF_FFFE;
    c0 = 32'hFFFF_FFF0;
    run_scn(1);
    idx = (wfall < 2) ? 0 : wfall - 2;
    chk("wrap_fall_total", -1, int'(tot[idx]), 2);
    chk("wrap_ee", -1, int'(enc_errors), 0);
    chk("wrap_fc", -1, int'(fail_code), 0);

    // reset mid-campaign, then a normal campaign without another reset
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
    @(negedge clk);
    chk("mid_busy_pre", -1, int'(busy), 1);
    chk("mid_crr_pre", -1, int'(chip_rst_req), 1);
    #2 rst = 1;
    #1;
    chk("mid_crr_async", -1, int'(chip_rst_req), 0);
    chk("mid_busy_async", -1, int'(busy), 0);
    chk("mid_enc_async", -1, int'(enc), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_no_done", -1, int'(done), 0);
    end
    rst = 0;
    cfg_random();
    run_scn(0);

    // randomized campaigns
    for (int i = 0; i < 5; i++) begin
      cfg_random();
      run_scn(1);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
